// File: rtl/common_pkg.sv
// -----------------------------------------------------------------------------
// common: basic word types shared across the core.
//   u32              32-bit unsigned word
//   u64              64-bit unsigned word / address
//   RESET_PC_DEFAULT first fetch address after reset unless overridden
// -----------------------------------------------------------------------------
package common;
    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

    localparam u64 RESET_PC_DEFAULT = 64'h8000_0000;
endpackage

// File: rtl/pipes_pkg.sv
// -----------------------------------------------------------------------------
// pipes: types describing the front-end pipeline.
//   fetch_state_e  fetch FSM states
//                    FETCH  request outstanding at pc
//                    HOLD   instruction held toward decode
//                    DRAIN  waiting out a request made stale by a redirect
//   fetch_out_t    fetch -> decode register (valid, pc, raw_instr)
// -----------------------------------------------------------------------------
package pipes;
    import common::*;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic valid;
        u64   pc;
        u32   raw_instr;
    } fetch_out_t;
endpackage

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit: single-outstanding instruction fetch with redirect support.
//
// Ports
//   clk             clock, all state on rising edge
//   reset           asynchronous active-high reset
//   ireq_valid      instruction-bus request valid (FETCH, DRAIN)
//   ireq_addr       request address, always word-aligned
//   iresp_data_ok   bus returns data this cycle
//   iresp_data      returned instruction word
//   instr_valid     raw_instr / instr_pc valid toward decode (HOLD only)
//   instr_ready     decode accepts this cycle
//   raw_instr       instruction word for decode
//   instr_pc        address of raw_instr
//   redirect_valid  redirect from a later stage
//   redirect_pc     redirect target, bits [1:0] forced to zero
//
// Handshakes: the bus request holds ireq_valid and ireq_addr stable until a
// cycle with iresp_data_ok, which completes it. Toward decode, an instruction
// transfers in a cycle with instr_valid & instr_ready & !redirect_valid; a
// redirect always wins over acceptance, so the held instruction is dropped.
// -----------------------------------------------------------------------------
module fetch_unit
    import common::*;
    import pipes::*;
#(
    parameter u64 RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] raw_instr,
    output logic [63:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc
);

    fetch_state_e state_q, state_d;
    u64           pc_q, pc_d;
    u64           target_q, target_d;
    fetch_out_t   out_q, out_d;
    u64           redirect_target;
    logic         fire;
    logic         req;
    logic         unused_low_bits;

    assign redirect_target = {redirect_pc[63:2], 2'b00};
    assign unused_low_bits = ^redirect_pc[1:0];
    assign fire            = out_q.valid & instr_ready & ~redirect_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            target_q <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            out_q    <= out_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        out_d    = out_q;
        req      = 1'b0;
        case (state_q)
            FETCH: begin
                req = 1'b1;
                if (redirect_valid) begin
                    if (iresp_data_ok) begin
                        // Response belongs to the old path; drop it and
                        // start the new path right away.
                        pc_d = redirect_target;
                    end else begin
                        target_d = redirect_target;
                        state_d  = DRAIN;
                    end
                end else if (iresp_data_ok) begin
                    out_d.valid     = 1'b1;
                    out_d.pc        = pc_q;
                    out_d.raw_instr = iresp_data;
                    state_d         = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    out_d.valid = 1'b0;
                    pc_d        = redirect_target;
                    state_d     = FETCH;
                end else if (fire) begin
                    out_d.valid = 1'b0;
                    pc_d        = pc_q + 64'd4;
                    state_d     = FETCH;
                end
            end
            DRAIN: begin
                // The old request must complete on the bus before a new one
                // can go out; its data is never captured.
                req = 1'b1;
                if (redirect_valid) begin
                    target_d = redirect_target;
                end
                if (iresp_data_ok) begin
                    pc_d    = redirect_valid ? redirect_target : target_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Gate with reset so the request drops the moment reset asserts.
    assign ireq_valid  = req & ~reset;
    assign ireq_addr   = pc_q;
    assign instr_valid = out_q.valid;
    assign raw_instr   = out_q.raw_instr;
    assign instr_pc    = out_q.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit: self-checking bench for fetch_unit.
// Reference model: the stream of instructions decode should receive, kept as a
// queue of expected pcs. A redirect replaces the stream with its aligned target,
// reset replaces it with RESET_PC, and each accepted instruction is followed by
// pc+4. Memory contents are a fixed function of the address.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic        clk;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] raw_instr;
    logic [63:0] instr_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    int checks = 0;
    int errors = 0;
    int fire_cnt = 0;
    logic [63:0] last_fire_pc = '0;
    logic [63:0] exp_q[$];

    // memory model state
    int          fixed_lat = 2;
    bit          busy = 0;
    int          cnt = 0;
    logic [63:0] req_addr = '0;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .raw_instr      (raw_instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == RESET_PC) return 32'h0010_0093;
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0F0F_1234;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    initial begin
        iresp_data_ok = 1'b0;
        iresp_data    = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                busy          = 0;
                iresp_data_ok = 1'b0;
            end else begin
                if (iresp_data_ok) begin
                    iresp_data_ok = 1'b0;
                    iresp_data    = $urandom;
                end
                if (busy) begin
                    check("req_stable_valid", {63'd0, ireq_valid}, 64'd1);
                    check("req_stable_addr", ireq_addr, req_addr);
                end else if (ireq_valid) begin
                    busy     = 1;
                    req_addr = ireq_addr;
                    cnt      = (fixed_lat < 0) ? $urandom_range(0, 4) : fixed_lat;
                    check("req_aligned", {62'd0, ireq_addr[1:0]}, 64'd0);
                end
                if (busy) begin
                    if (cnt == 0) begin
                        iresp_data_ok = 1'b1;
                        iresp_data    = mem_word(req_addr);
                        busy          = 0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (instr_valid) check("hold_no_req", {63'd0, ireq_valid}, 64'd0);
                if (instr_valid && instr_ready && !redirect_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_empty: got pc %h expected no transfer", instr_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_pc", instr_pc, e);
                        check("sb_instr", {32'd0, raw_instr}, {32'd0, mem_word(e)});
                        exp_q.push_back(e + 64'd4);
                    end
                    fire_cnt++;
                    last_fire_pc = instr_pc;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_q.push_back(RESET_PC);
    endtask

    task automatic apply_redirect(input logic [63:0] t);
        redirect_valid = 1'b1;
        redirect_pc    = t;
        exp_q.delete();
        exp_q.push_back({t[63:2], 2'b00});
    endtask

    task automatic send_redirect(input logic [63:0] t);
        apply_redirect(t);
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (instr_valid) begin
                ok = 1;
                break;
            end
        end
        check(name, {63'd0, ok}, 64'd1);
    endtask

    task automatic wait_pending(input string name, input int min_cnt);
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (busy && cnt >= min_cnt) begin
                ok = 1;
                break;
            end
        end
        check(name, {63'd0, ok}, 64'd1);
    endtask

    task automatic check_next_addr(input string name, input logic [63:0] old, input logic [63:0] exp);
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ireq_valid && ireq_addr != old) begin
                ok = 1;
                check(name, ireq_addr, exp);
                break;
            end
        end
        if (!ok) check({name, "_timeout"}, {63'd0, ok}, 64'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] held_instr;
        logic [63:0] held_pc;
        logic [63:0] old;
        int          start_fires;

        reset          = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        model_reset();

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
        check("rst_instr_valid", {63'd0, instr_valid}, 64'd0);
        check("rst_raw_instr", {32'd0, raw_instr}, 64'd0);
        check("rst_instr_pc", instr_pc, 64'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("first_req_valid", {63'd0, ireq_valid}, 64'd1);
        check("first_req_addr", ireq_addr, RESET_PC);

        // first instruction, then the sequential fetch
        step();
        instr_ready = 1'b1;
        wait_valid("t1_valid_timeout");
        check("t1_raw", {32'd0, raw_instr}, 64'h0000_0000_0010_0093);
        check("t1_pc", instr_pc, RESET_PC);
        step();
        @(negedge clk);
        check("t1_next_valid", {63'd0, ireq_valid}, 64'd1);
        check("t1_next_addr", ireq_addr, 64'h8000_0004);

        // decode stall: output held stable, no bus request
        step();
        instr_ready = 1'b0;
        wait_valid("t2_valid_timeout");
        held_instr = raw_instr;
        held_pc    = instr_pc;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_valid", {63'd0, instr_valid}, 64'd1);
            check("t2_raw", {32'd0, raw_instr}, {32'd0, held_instr});
            check("t2_pc", instr_pc, held_pc);
            check("t2_no_req", {63'd0, ireq_valid}, 64'd0);
        end
        step();
        instr_ready = 1'b1;

        // redirect while a request is pending -> drain the old request
        fixed_lat = 4;
        wait_pending("t3_pending_timeout", 2);
        old = ireq_addr;
        send_redirect(64'h8000_0103);
        @(negedge clk);
        check("t3_drain_valid", {63'd0, ireq_valid}, 64'd1);
        check("t3_drain_addr", ireq_addr, old);
        check_next_addr("t3_next_addr", old, 64'h8000_0100);

        // redirect and ready together in HOLD -> no transfer
        step();
        instr_ready = 1'b0;
        fixed_lat   = 1;
        wait_valid("t4_valid_timeout");
        step();
        instr_ready = 1'b1;
        start_fires = fire_cnt;
        send_redirect(64'h8000_0400);
        check("t4_no_fire", fire_cnt, start_fires);
        check_next_addr("t4_next_addr", 64'h1, 64'h8000_0400);

        // two redirects during DRAIN -> latest wins
        step();
        fixed_lat = 6;
        wait_pending("t5_pending_timeout", 2);
        old = ireq_addr;
        send_redirect(64'h200);
        send_redirect(64'h300);
        check_next_addr("t5_next_addr", old, 64'h300);

        // 64-bit pc wrap
        fixed_lat = 1;
        step();
        send_redirect(64'hFFFF_FFFF_FFFF_FFFE);
        start_fires = fire_cnt;
        for (int i = 0; i < 60 && fire_cnt < start_fires + 2; i++) step();
        check("wrap_pc", last_fire_pc, 64'd0);

        // reset mid-FETCH
        fixed_lat = 4;
        wait_pending("t6_pending_timeout", 2);
        reset = 1'b1;
        model_reset();
        #1;
        check("t6_req_drop", {63'd0, ireq_valid}, 64'd0);
        check("t6_instr_drop", {63'd0, instr_valid}, 64'd0);
        step();
        step();
        reset = 1'b0;
        @(negedge clk);
        check("t6_restart_valid", {63'd0, ireq_valid}, 64'd1);
        check("t6_restart_addr", ireq_addr, RESET_PC);

        // randomized traffic
        fixed_lat   = -1;
        start_fires = fire_cnt;
        for (int i = 0; i < 600; i++) begin
            step();
            instr_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 11) == 0)
                apply_redirect(64'h8000_0000 + 64'($urandom_range(0, 4095)));
            else
                redirect_valid = 1'b0;
        end
        step();
        redirect_valid = 1'b0;
        repeat (10) step();
        check("random_fires", {63'd0, fire_cnt > start_fires}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
